// File: rtl/me_pkg.sv
// me_pkg: shared constants and types for the motion-estimation SAD search.
//   PIX_W    - bits per pixel
//   BLK_PIX  - pixels per 8x8 block
//   BLK_W    - packed block width (pixel i at bits [8i+7:8i])
//   ROW_W    - width of one 8-pixel row SAD (8 x 255 = 2040)
//   SAD_W    - width of a full block SAD (64 x 255 = 16320)
//   SAD_INIT - starting value of the running minimum
//   me_state_e - search controller states
package me_pkg;

  localparam int PIX_W   = 8;
  localparam int BLK_PIX = 64;
  localparam int BLK_W   = BLK_PIX * PIX_W;
  localparam int ROW_W   = 11;
  localparam int SAD_W   = 14;

  localparam logic [SAD_W-1:0] SAD_INIT = 14'd16383;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DRAIN,
    DONE
  } me_state_e;

endpackage

// File: rtl/sad_row8.sv
// sad_row8: one row slice of the SAD datapath.
//   clk       - clock
//   en_i      - pipeline enable; low holds both stages
//   cur_row_i - 8 current-block pixels, pixel j at bits [8j+7:8j]
//   ref_row_i - 8 candidate pixels, same packing
//   row_sum_o - registered sum of the 8 absolute differences (two cycles)
// Data registers carry no reset: their meaning is qualified by the valid
// pipeline held in the top level.
module sad_row8
  import me_pkg::*;
(
  input  logic                 clk,
  input  logic                 en_i,
  input  logic [8*PIX_W-1:0]   cur_row_i,
  input  logic [8*PIX_W-1:0]   ref_row_i,
  output logic [ROW_W-1:0]     row_sum_o
);

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [PIX_W-1:0] ad_p1 [8];
  logic [ROW_W-1:0] row_acc;
  logic [ROW_W-1:0] sum_p2;

  // ---- stage 1: per-pixel absolute difference
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int j = 0; j < 8; j++) begin
        ad_p1[j] <= abs_diff(cur_row_i[j*PIX_W +: PIX_W], ref_row_i[j*PIX_W +: PIX_W]);
      end
    end
  end

  always_comb begin
    row_acc = '0;
    for (int j = 0; j < 8; j++) begin
      row_acc = row_acc + ROW_W'(ad_p1[j]);
    end
  end

  // ---- stage 2: row sum
  always_ff @(posedge clk) begin
    if (en_i) sum_p2 <= row_acc;
  end

  assign row_sum_o = sum_p2;

endmodule

// File: rtl/sad_min_search.sv
// sad_min_search: full-search minimum-SAD matcher for one 8x8 current block.
//   clk, rst (async, active-low), en (global freeze when low)
//   cur_valid/cur_ready/cur_block  - current block handshake (ready only in IDLE)
//   ref_valid/ref_ready/ref_block  - candidate stream, ref_mv_x/ref_mv_y tag
//   best_sad, best_mv_x, best_mv_y - running minimum and its vector
//   busy  - SEARCH or DRAIN;  done - one-cycle result pulse (DONE state)
// Optional macro SAD_EARLY_EXIT_EN: stop accepting candidates once a zero
// SAD has been recorded as the best match.
module sad_min_search
  import me_pkg::*;
#(
  parameter int CAND_NUM = 289,
  parameter int MV_W     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cur_valid,
  output logic                    cur_ready,
  input  logic [BLK_W-1:0]        cur_block,
  input  logic                    ref_valid,
  output logic                    ref_ready,
  input  logic [BLK_W-1:0]        ref_block,
  input  logic signed [MV_W-1:0]  ref_mv_x,
  input  logic signed [MV_W-1:0]  ref_mv_y,
  output logic [SAD_W-1:0]        best_sad,
  output logic signed [MV_W-1:0]  best_mv_x,
  output logic signed [MV_W-1:0]  best_mv_y,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = $clog2(CAND_NUM + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CAND_NUM - 1);
  localparam logic [CNT_W-1:0] CAND_CNT = CNT_W'(CAND_NUM);

`ifdef SAD_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  me_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SAD_W-1:0]       best_sad_q, best_sad_d;
  logic signed [MV_W-1:0] best_mv_x_q, best_mv_x_d;
  logic signed [MV_W-1:0] best_mv_y_q, best_mv_y_d;
  logic [BLK_W-1:0]       cur_q;

  logic                   vld_p1, vld_p2, vld_p3;
  logic signed [MV_W-1:0] mv_x_p1, mv_x_p2, mv_x_p3;
  logic signed [MV_W-1:0] mv_y_p1, mv_y_p2, mv_y_p3;
  logic [ROW_W-1:0]       row_sum_p2 [8];
  logic [SAD_W-1:0]       total_d, total_p3;
  logic                   better;

  // ---- stages 1 and 2: row abs-diff and row sums
  for (genvar r = 0; r < 8; r++) begin : g_row
    sad_row8 u_row (
      .clk       (clk),
      .en_i      (en),
      .cur_row_i (cur_q[r*8*PIX_W +: 8*PIX_W]),
      .ref_row_i (ref_block[r*8*PIX_W +: 8*PIX_W]),
      .row_sum_o (row_sum_p2[r])
    );
  end

  always_comb begin
    total_d = '0;
    for (int r = 0; r < 8; r++) begin
      total_d = total_d + SAD_W'(row_sum_p2[r]);
    end
  end

  // Strict compare: ties keep the earlier candidate.
  assign better = vld_p3 && (total_p3 < best_sad_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    best_sad_d  = best_sad_q;
    best_mv_x_d = best_mv_x_q;
    best_mv_y_d = best_mv_y_q;
    cur_ready   = (state_q == IDLE);
    ref_ready   = (state_q == SEARCH) && (cnt_q < CAND_CNT);
    busy        = (state_q == SEARCH) || (state_q == DRAIN);
    done        = (state_q == DONE);

    if (better) begin
      best_sad_d  = total_p3;
      best_mv_x_d = mv_x_p3;
      best_mv_y_d = mv_y_p3;
    end

    case (state_q)
      IDLE: begin
        if (cur_valid) begin
          state_d    = SEARCH;
          cnt_d      = '0;
          best_sad_d = SAD_INIT;
        end
      end
      SEARCH: begin
        if (ref_valid && ref_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) state_d = DRAIN;
        end
        // A zero SAD cannot be beaten, so remaining candidates are pointless.
        if (EARLY_EXIT && better && (total_p3 == '0)) state_d = DRAIN;
      end
      DRAIN: begin
        if (!(vld_p1 || vld_p2 || vld_p3)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      best_sad_q  <= SAD_INIT;
      best_mv_x_q <= '0;
      best_mv_y_q <= '0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      vld_p3      <= 1'b0;
    end else if (en) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      best_sad_q  <= best_sad_d;
      best_mv_x_q <= best_mv_x_d;
      best_mv_y_q <= best_mv_y_d;
      vld_p1      <= ref_valid && ref_ready;
      vld_p2      <= vld_p1;
      vld_p3      <= vld_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if ((state_q == IDLE) && cur_valid) cur_q <= cur_block;
      mv_x_p1  <= ref_mv_x;
      mv_y_p1  <= ref_mv_y;
      mv_x_p2  <= mv_x_p1;
      mv_y_p2  <= mv_y_p1;
      // ---- stage 3: block total
      mv_x_p3  <= mv_x_p2;
      mv_y_p3  <= mv_y_p2;
      total_p3 <= total_d;
    end
  end

  assign best_sad  = best_sad_q;
  assign best_mv_x = best_mv_x_q;
  assign best_mv_y = best_mv_y_q;

endmodule

// File: tb/tb_sad_min_search.sv
module tb_sad_min_search;

  localparam int MV_W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, en;
  logic                   cur_valid, cur_ready, ref_valid, ref_ready;
  logic [511:0]           cur_block, ref_block;
  logic signed [MV_W-1:0] ref_mv_x, ref_mv_y, best_mv_x, best_mv_y;
  logic [13:0]            best_sad;
  logic                   busy, done;

  logic                   cur_valid2, cur_ready2, ref_valid2, ref_ready2;
  logic [511:0]           cur_block2, ref_block2;
  logic signed [MV_W-1:0] ref_mv_x2, ref_mv_y2, best_mv_x2, best_mv_y2;
  logic [13:0]            best_sad2;
  logic                   busy2, done2;

  sad_min_search #(.CAND_NUM(289), .MV_W(MV_W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .cur_valid(cur_valid), .cur_ready(cur_ready), .cur_block(cur_block),
    .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_block(ref_block),
    .ref_mv_x(ref_mv_x), .ref_mv_y(ref_mv_y),
    .best_sad(best_sad), .best_mv_x(best_mv_x), .best_mv_y(best_mv_y),
    .busy(busy), .done(done)
  );

  sad_min_search #(.CAND_NUM(1), .MV_W(MV_W)) dut1 (
    .clk(clk), .rst(rst), .en(en),
    .cur_valid(cur_valid2), .cur_ready(cur_ready2), .cur_block(cur_block2),
    .ref_valid(ref_valid2), .ref_ready(ref_ready2), .ref_block(ref_block2),
    .ref_mv_x(ref_mv_x2), .ref_mv_y(ref_mv_y2),
    .best_sad(best_sad2), .best_mv_x(best_mv_x2), .best_mv_y(best_mv_y2),
    .busy(busy2), .done(done2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] cur_pix(input int mode, input int i);
    if (mode == 4) return 8'(i * 3);
    return 8'h10;
  endfunction

  // mode 1: one 0x11 block (SAD 64) among 0x12 (SAD 128)
  // mode 2: two SAD-128 blocks first, the rest SAD 192
  // mode 3: exact match at candidate 10
  // mode 4: graded current block, candidate 7 off by +2/-1 alternately (SAD 96)
  function automatic logic [7:0] ref_pix(input int mode, input int idx, input int i);
    case (mode)
      1: return (idx == 100) ? 8'h11 : 8'h12;
      2: return (idx < 2) ? 8'h12 : 8'h13;
      3: return (idx == 10) ? 8'h10 : 8'h12;
      4: begin
        if (idx != 7) return 8'h00;
        return (i % 2 == 0) ? 8'(i * 3 + 2) : 8'(i * 3 - 1);
      end
      default: return 8'h00;
    endcase
  endfunction

  function automatic int mvx(input int mode, input int idx);
    if (mode == 1 && idx == 100) return -3;
    if (mode == 2 && idx == 0) return 1;
    if (mode == 2 && idx == 1) return 2;
    if (mode == 3 && idx == 10) return 5;
    if (mode == 4 && idx == 7) return -7;
    return idx % 17 - 8;
  endfunction

  function automatic int mvy(input int mode, input int idx);
    if (mode == 1 && idx == 100) return 2;
    if (mode == 2 && idx == 0) return 1;
    if (mode == 2 && idx == 1) return 2;
    if (mode == 3 && idx == 10) return -4;
    if (mode == 4 && idx == 7) return 9;
    return idx / 17 - 8;
  endfunction

  task automatic run_search(input int mode, input bit rnd, input int gap_at,
                            input int rst_at, output int n_acc, output int lat);
    int cyc, last, gap;
    bit acc, got;
    n_acc = 0; lat = -1; cyc = 0; last = 0; gap = 0; got = 0;
    for (int i = 0; i < 64; i++) cur_block[i*8 +: 8] = cur_pix(mode, i);
    en = 1'b1;
    cur_valid = 1'b1;
    step();
    cur_valid = 1'b0;
    cur_block = '1;  // must not be resampled outside IDLE
    chk("busy_after_start", busy, 1);
    chk("cur_ready_after_start", cur_ready, 0);
    chk("best_sad_reinit", best_sad, 16383);
    while (cyc < 2000 && !got) begin
      ref_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int i = 0; i < 64; i++) ref_block[i*8 +: 8] = ref_pix(mode, n_acc, i);
      ref_mv_x = MV_W'(mvx(mode, n_acc));
      ref_mv_y = MV_W'(mvy(mode, n_acc));
      if (n_acc == gap_at && gap < 5) begin
        en = 1'b0;
        gap++;
      end else begin
        en = 1'b1;
      end
      if (n_acc == rst_at) begin
        rst = 1'b0;
        #1;
        chk("rst_cur_ready", cur_ready, 1);
        chk("rst_ref_ready", ref_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_best_sad", best_sad, 16383);
        chk("rst_mv_x", best_mv_x, 0);
        chk("rst_mv_y", best_mv_y, 0);
        step();
        rst = 1'b1;
        ref_valid = 1'b0;
        en = 1'b1;
        return;
      end
      acc = ref_valid && ref_ready && en;
      step();
      cyc++;
      if (acc) begin
        n_acc++;
        last = cyc;
      end
      if (!en) begin
        chk("frozen_busy", busy, 1);
        chk("frozen_ref_ready", ref_ready, 1);
      end
      if (done) begin
        got = 1'b1;
        lat = cyc - last;
      end
    end
    ref_valid = 1'b0;
    en = 1'b1;
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic after_done(input string tag, input int sad);
    step();
    chk({tag, "_cur_ready_back"}, cur_ready, 1);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_sad_hold"}, best_sad, sad);
  endtask

  int n, lat, n2, lat2, last2;
  bit got2, acc2;

  initial begin
    rst = 1'b0; en = 1'b1;
    cur_valid = 0; ref_valid = 0; cur_block = '0; ref_block = '0;
    ref_mv_x = '0; ref_mv_y = '0;
    cur_valid2 = 0; ref_valid2 = 0; cur_block2 = '0; ref_block2 = '0;
    ref_mv_x2 = '0; ref_mv_y2 = '0;
    step(); step();
    chk("reset_cur_ready", cur_ready, 1);
    chk("reset_ref_ready", ref_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_best_sad", best_sad, 16383);
    chk("reset_mv_x", best_mv_x, 0);
    chk("reset_mv_y", best_mv_y, 0);
    chk("reset2_best_sad", best_sad2, 16383);
    rst = 1'b1;
    step();

    // single minimum, gap-free
    run_search(1, 1'b0, -1, -1, n, lat);
    chk("t1_count", n, 289);
    chk("t1_latency", lat, 4);
    chk("t1_sad", best_sad, 64);
    chk("t1_mv_x", best_mv_x, -3);
    chk("t1_mv_y", best_mv_y, 2);
    chk("t1_busy_in_done", busy, 0);
    after_done("t1", 64);

    // tie keeps the first candidate
    run_search(2, 1'b0, -1, -1, n, lat);
    chk("tie_sad", best_sad, 128);
    chk("tie_mv_x", best_mv_x, 1);
    chk("tie_mv_y", best_mv_y, 1);
    after_done("tie", 128);

    // graded pixels, both difference signs
    run_search(4, 1'b0, -1, -1, n, lat);
    chk("grad_sad", best_sad, 96);
    chk("grad_mv_x", best_mv_x, -7);
    chk("grad_mv_y", best_mv_y, 9);
    after_done("grad", 96);

    // random ref_valid bubbles and a 5-cycle enable drop
    run_search(1, 1'b1, 60, -1, n, lat);
    chk("rnd_count", n, 289);
    chk("rnd_latency", lat, 4);
    chk("rnd_sad", best_sad, 64);
    chk("rnd_mv_x", best_mv_x, -3);
    chk("rnd_mv_y", best_mv_y, 2);
    after_done("rnd", 64);

    // reset mid-search, then a fresh search
    run_search(1, 1'b0, -1, 50, n, lat);
    step();
    run_search(4, 1'b0, -1, -1, n, lat);
    chk("post_rst_count", n, 289);
    chk("post_rst_sad", best_sad, 96);
    chk("post_rst_mv_x", best_mv_x, -7);
    chk("post_rst_mv_y", best_mv_y, 9);
    after_done("post_rst", 96);

    // exact match at candidate 10
    run_search(3, 1'b0, -1, -1, n, lat);
`ifdef SAD_EARLY_EXIT_EN
    chk("exact_count", n, 14);
`else
    chk("exact_count", n, 289);
`endif
    chk("exact_latency", lat, 4);
    chk("exact_sad", best_sad, 0);
    chk("exact_mv_x", best_mv_x, 5);
    chk("exact_mv_y", best_mv_y, -4);
    chk("exact_ref_ready", ref_ready, 0);
    after_done("exact", 0);

    // CAND_NUM=1 instance: worst-case SAD
    cur_block2 = '0;
    cur_valid2 = 1'b1;
    step();
    cur_valid2 = 1'b0;
    ref_block2 = '1;
    ref_mv_x2 = -6'sd1;
    ref_mv_y2 = 6'sd3;
    ref_valid2 = 1'b1;
    n2 = 0; got2 = 0; last2 = 0; lat2 = -1;
    for (int c = 1; c <= 20 && !got2; c++) begin
      acc2 = ref_valid2 && ref_ready2;
      step();
      if (acc2) begin
        n2++;
        last2 = c;
        ref_valid2 = 1'b0;
      end
      if (done2) begin
        got2 = 1'b1;
        lat2 = c - last2;
      end
    end
    ref_valid2 = 1'b0;
    if (!got2) chk("one_done_timeout", 0, 1);
    chk("one_count", n2, 1);
    chk("one_latency", lat2, 4);
    chk("one_sad", best_sad2, 16320);
    chk("one_mv_x", best_mv_x2, -1);
    chk("one_mv_y", best_mv_y2, 3);
    step();
    chk("one_cur_ready_back", cur_ready2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
